// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Wait-stated RV32I data-memory responder (LB/LH/LW/LBU/LHU,
//            SB/SH/SW). Optional macro DMEM_MISALIGN_TRAP_EN enables the
//            misalignment / illegal-Funct3M trap.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  Funct3M,
    output logic [31:0] ReadData,
    output logic        StallMem,
    output logic        MisalignM
);

    localparam int         AW          = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   read_data_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_valid;
    logic          w_commit;
    logic          w_is_byte;
    logic          w_is_half;
    logic          w_signed;
    logic [1:0]    w_lane;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_unused_addr;

    assign w_req         = MemReadM | MemWriteM;
    assign w_idx         = ALUResultM[AW+1:2];
    assign w_unused_addr = ^ALUResultM[31:AW+2];
    assign w_signed      = ~Funct3M[2];

    // Stores only know 000/001 as sub-word sizes; anything else acts as a word.
    always_comb begin
        w_is_byte = 1'b0;
        w_is_half = 1'b0;
        if (MemWriteM) begin
            w_is_byte = (Funct3M == 3'b000);
            w_is_half = (Funct3M == 3'b001);
        end else begin
            w_is_byte = (Funct3M[1:0] == 2'b00);
            w_is_half = (Funct3M[1:0] == 2'b01);
        end
    end

    // Lane is forced to natural alignment; trapped requests never reach the array.
    assign w_lane = w_is_byte ? ALUResultM[1:0] :
                    w_is_half ? {ALUResultM[1], 1'b0} : 2'b00;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_illegal;
    assign w_illegal = (Funct3M == 3'b011) || (Funct3M[2:1] == 2'b11) ||
                       (MemWriteM && (Funct3M[2:1] == 2'b10));
    assign MisalignM = w_req && (w_illegal ||
                                 (w_is_half && ALUResultM[0]) ||
                                 (!w_is_byte && !w_is_half && (ALUResultM[1:0] != 2'b00)));
`else
    assign MisalignM = 1'b0;
`endif

    assign w_valid = w_req && !MisalignM;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{WriteDataM[15:0]}};
        end
    end

    assign w_word = mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{w_lane, 3'b000} +: 16];

    always_comb begin
        w_load = w_word;
        if (w_is_byte) begin
            w_load = {{24{w_signed & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load = {{16{w_signed & w_half[15]}}, w_half};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_valid) begin
                    cnt_d   = C_WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    w_commit = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign StallMem = ((state_q == S_IDLE) && w_valid) || (state_q == S_WAIT);
    assign ReadData = read_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_commit && !MemWriteM) begin
                read_data_q <= w_load;
            end
        end
    end

    // A reset landing on the commit edge abandons the store.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && MemWriteM) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder: directed vector table,
//            reset-abort sequences and randomized traffic vs a byte model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;
    localparam int NBYTE = DEPTH * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, ReadData;
    logic [2:0]  Funct3M;
    logic        StallMem, MisalignM;

    int total = 0;
    int bad   = 0;

    logic [7:0] bm [NBYTE];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        bit          exp_mis;
    } vec_t;

    vec_t vecs [21];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .Funct3M    (Funct3M),
        .ReadData   (ReadData),
        .StallMem   (StallMem),
        .MisalignM  (MisalignM)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Access size in bytes from RV32I Funct3 rules; unknown codes act as word.
    function automatic int sz(input bit wr, input logic [2:0] f3);
        if (wr) begin
            case (f3)
                3'b000:  return 1;
                3'b001:  return 2;
                default: return 4;
            endcase
        end
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit model_mis(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        bit m;
        int n;
        n = sz(wr, f3);
        m = (rd || wr) && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
                           (wr && ((f3 == 3'd4) || (f3 == 3'd5))) ||
                           ((a % n) != 0));
        if (!TRAP) m = 1'b0;
        return m;
    endfunction

    function automatic int base_of(input logic [31:0] a, input int n);
        return int'((a - (a % n)) % NBYTE);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
        int          n, b;
        logic [31:0] v;
        n = sz(1'b0, f3);
        b = base_of(a, n);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(bm[b+i]) << (8*i));
        if (n < 4 && f3[2] == 1'b0 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        int n, b;
        n = sz(1'b1, f3);
        b = base_of(a, n);
        for (int i = 0; i < n; i++) bm[b+i] = wd[8*i +: 8];
    endtask

    task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] f3);
        if ((rd || wr) && !model_mis(rd, wr, f3, a) && wr) model_write(a, wd, f3);
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output int stalls, output logic mis, output logic [31:0] rdat);
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = wd; Funct3M = f3;
        #1;
        mis    = MisalignM;
        stalls = 0;
        while (StallMem && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls == 0) begin
            @(negedge clk);
            #1;
        end
        rdat = ReadData;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                input logic [31:0] exp_rd, input bit exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.f3 = f3;
        v.exp_rd = exp_rd; v.exp_mis = exp_mis;
        return v;
    endfunction

    initial begin
        int          st;
        logic        mis;
        logic [31:0] rdat, exp_rd, a, wd;
        logic [2:0]  f3;
        bit          rd, wr, em;
        int          kind;
        int          rst_at [2] = '{1, 3};

        vecs[0]  = mk(0, 1, 32'h20,  32'hCAFEF00D, 3'b010, 32'h0, 0);
        vecs[1]  = mk(0, 1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0, 0);
        vecs[2]  = mk(1, 0, 32'h10,  32'h0, 3'b010, 32'hDEADBEEF, 0);
        vecs[3]  = mk(0, 1, 32'h13,  32'h12345680, 3'b000, 32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 0, 32'h13,  32'h0, 3'b000, 32'hFFFFFF80, 0);
        vecs[5]  = mk(1, 0, 32'h13,  32'h0, 3'b100, 32'h00000080, 0);
        vecs[6]  = mk(1, 0, 32'h10,  32'h0, 3'b010, 32'h80ADBEEF, 0);
        vecs[7]  = mk(1, 0, 32'h12,  32'h0, 3'b001, 32'hFFFF80AD, 0);
        vecs[8]  = mk(1, 0, 32'h410, 32'h0, 3'b010, 32'h80ADBEEF, 0);
        vecs[9]  = mk(1, 0, 32'h12,  32'h0, 3'b101, 32'h000080AD, 0);
        vecs[10] = mk(1, 0, 32'h11,  32'h0, 3'b010, TRAP ? 32'h000080AD : 32'h80ADBEEF, TRAP);
        vecs[11] = mk(0, 1, 32'h22,  32'hAAAABEEF, 3'b001, TRAP ? 32'h000080AD : 32'h80ADBEEF, 0);
        vecs[12] = mk(1, 0, 32'h20,  32'h0, 3'b010, 32'hBEEFF00D, 0);
        vecs[13] = mk(1, 1, 32'h21,  32'h00000055, 3'b000, 32'hBEEFF00D, 0);
        vecs[14] = mk(1, 0, 32'h20,  32'h0, 3'b010, 32'hBEEF550D, 0);
        vecs[15] = mk(0, 1, 32'h23,  32'h11111111, 3'b010, 32'hBEEF550D, TRAP);
        vecs[16] = mk(1, 0, 32'h20,  32'h0, 3'b010, TRAP ? 32'hBEEF550D : 32'h11111111, 0);
        vecs[17] = mk(1, 0, 32'h10,  32'h0, 3'b011, TRAP ? 32'hBEEF550D : 32'h80ADBEEF, TRAP);
        vecs[18] = mk(0, 0, 32'h03,  32'h0, 3'b011, TRAP ? 32'hBEEF550D : 32'h80ADBEEF, 0);
        vecs[19] = mk(0, 1, 32'h14,  32'h0, 3'b100, TRAP ? 32'hBEEF550D : 32'h80ADBEEF, TRAP);
        vecs[20] = mk(1, 0, 32'h13,  32'h0, 3'b001, TRAP ? 32'hBEEF550D : 32'hFFFF80AD, TRAP);

        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = 32'h0; WriteDataM = 32'h0; Funct3M = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ReadData", ReadData, 32'h0);
        check("reset StallMem", 32'(StallMem), 32'h0);
        check("reset MisalignM", 32'(MisalignM), 32'h0);

        for (int i = 0; i < 21; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, st, mis, rdat);
            check($sformatf("vec%0d misalign", i), 32'(mis), 32'(vecs[i].exp_mis));
            check($sformatf("vec%0d stalls", i), st,
                  (vecs[i].exp_mis || !(vecs[i].rd || vecs[i].wr)) ? 0 : WAITC + 2);
            check($sformatf("vec%0d rdata", i), rdat, vecs[i].exp_rd);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3);
        end

        // Reset during WAIT (early, and on the would-be commit edge) abandons the store.
        foreach (rst_at[k]) begin
            @(negedge clk);
            MemReadM = 1'b0; MemWriteM = 1'b1; ALUResultM = 32'h20;
            WriteDataM = 32'h12345678; Funct3M = 3'b010;
            repeat (rst_at[k]) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; MemWriteM = 1'b0;
            #1;
            check($sformatf("rst%0d StallMem", k), 32'(StallMem), 32'h0);
            check($sformatf("rst%0d ReadData", k), ReadData, 32'h0);
            access(1, 0, 32'h20, 32'h0, 3'b010, st, mis, rdat);
            check($sformatf("rst%0d reload", k), rdat, model_read(32'h20, 3'b010));
            check($sformatf("rst%0d reload stalls", k), st, WAITC + 2);
        end
        exp_rd = model_read(32'h20, 3'b010);

        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            access(0, 1, 32'(w * 4), wd, 3'b010, st, mis, rdat);
            model_write(32'(w * 4), wd, 3'b010);
        end

        for (int n = 0; n < 60; n++) begin
            f3   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 3);
            rd   = (kind != 1);
            wr   = (kind == 1) || (kind == 2);
            a    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            wd   = $urandom;
            em   = model_mis(rd, wr, f3, a);
            if (!em && !wr) exp_rd = model_read(a, f3);
            access(rd, wr, a, wd, f3, st, mis, rdat);
            check($sformatf("rnd%0d misalign", n), 32'(mis), 32'(em));
            check($sformatf("rnd%0d stalls", n), st, em ? 0 : WAITC + 2);
            check($sformatf("rnd%0d rdata", n), rdat, exp_rd);
            model_apply(rd, wr, a, wd, f3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the MEM stage. It accepts load/store requests from the pipeline, applies a configurable number of wait states while stalling the pipeline, and performs RISC-V byte, halfword and word accesses on an internal word-organised array. It returns sign- or zero-extended load data as `ReadData`, which the MEM/WB register captures.

## Interface
- `DEPTH_WORDS`, default 256: array depth in 32-bit words; power of two, minimum 4.
- `WAIT_CYCLES`, default 2: extra wait states per access; range 0..15.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `MemReadM`  in  1  load request.
- `MemWriteM`  in  1  store request.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store data; the low bits are used for SB/SH.
- `Funct3M`  in  3  access size and signedness (RV32I encoding).
- `ReadData`  out  32  registered load result; holds the last load value.
- `StallMem`  out  1  combinational; when high, the pipeline freezes all stages up to and including MEM.
- `MisalignM`  out  1  combinational; high when the current request is misaligned or has an illegal `Funct3M`.

## Operation
- FSM states: IDLE, WAIT, DONE. 4-bit counter `cnt`.
- **IDLE**
  - A valid request (`MemReadM|MemWriteM`, and not `MisalignM`) loads `cnt=WAIT_CYCLES` and moves to WAIT.
  - Otherwise the FSM stays in IDLE.
- **WAIT**
  - If `cnt!=0`: decrement `cnt`.
  - If `cnt==0`: perform the access at this edge and go to DONE.
- **DONE**
  - Request inputs are ignored.
  - Unconditional transition to IDLE.
- `StallMem` is high in IDLE with a valid request and in all of WAIT. It is low in DONE and for invalid or absent requests.
- The pipeline holds the M-stage inputs stable while `StallMem` is high.
- Word index is `ALUResultM[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap.
- Loads, result written into `ReadData`:
  - 000 LB: byte selected by `addr[1:0]`, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword selected by `addr[1]`, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word.
- Stores, with byte enables:
  - 000 SB: writes `WriteDataM[7:0]` to lane `addr[1:0]`.
  - 001 SH: writes `WriteDataM[15:0]` to lanes selected by `addr[1]`.
  - 010 SW: writes all four lanes.
  - Unselected lanes are untouched.
- `MisalignM` conditions:
  - Halfword access with `addr[0]=1`.
  - Word access with `addr[1:0]!=0`.
  - `Funct3M` of 011, 110 or 111, for either loads or stores.
  - Stores with `Funct3M` of 100 or 101.
- For a flagged request: no stall, no array change, `ReadData` unchanged, FSM stays in IDLE.
- `MemReadM` and `MemWriteM` both high: the store is performed and `ReadData` is unchanged.
- Reset values: state IDLE, `cnt=0`, `ReadData=0`, `StallMem=0`. `MisalignM` is combinational and therefore 0 when no request is present.
- Array contents are not cleared by reset.

## Timing
- Request first present in cycle 0 (IDLE):
  - `StallMem` is high in cycles 0..`WAIT_CYCLES+1`, i.e. `WAIT_CYCLES+2` cycles.
  - The access commits at the end of cycle `WAIT_CYCLES+1`.
  - Cycle `WAIT_CYCLES+2` is DONE: `StallMem=0`, `ReadData` is valid, and MEM/WB captures it at the end of that cycle.
- Back-to-back accesses: the next request is seen in IDLE the cycle after DONE. Throughput is one access per `WAIT_CYCLES+3` cycles.
- `WAIT_CYCLES=0` gives 2 stall cycles and 3 cycles total per access.
- `rst` asserted in any state, including mid-WAIT: the pending access is abandoned with no write and no `ReadData` update. The next cycle is IDLE with `StallMem` driven purely by the inputs.

## Configuration
- `DMEM_MISALIGN_TRAP_EN`
  - Defined: misalignment detection as described above. Flagged requests are suppressed and `MisalignM` is raised.
  - Undefined: `MisalignM` is tied to 0. Address low bits are forced to natural alignment (halfword clears `addr[0]`, word clears `addr[1:0]`). Illegal `Funct3M` values behave as LW/SW.

## Test plan
All scenarios use `WAIT_CYCLES=2` and `DMEM_MISALIGN_TRAP_EN` defined unless noted.

- **Reset:** hold `rst` 2 cycles with no request -> `ReadData=0`, `StallMem=0`, `MisalignM=0`.
- **Word store/load:** SW `0xDEADBEEF` @`0x10`, then LW @`0x10` -> `StallMem` high exactly 4 cycles per access; `ReadData=0xDEADBEEF` in the DONE cycle of the load.
- **Byte access:** SB `0x80` @`0x13`, then:
  - LB @`0x13` -> `0xFFFFFF80`
  - LBU @`0x13` -> `0x00000080`
  - LW @`0x10` -> `0x80ADBEEF`
- **Halfword access:** LH @`0x12` -> `0xFFFF80AD`; LHU @`0x12` -> `0x000080AD`. Address `0x410` with depth 256 aliases `0x10`, so LW -> `0x80ADBEEF`.
- **Misaligned load:**
  - Macro defined: LW @`0x11` -> `MisalignM=1`, `StallMem=0`, `ReadData` unchanged.
  - Macro undefined: same request -> `MisalignM=0`, and after the normal latency `ReadData` equals the word @`0x10`.
- **Reset mid-operation:** SW `0x12345678` @`0x20` with `rst` pulsed during WAIT -> no write; a subsequent LW @`0x20` returns the prior contents; `StallMem=0` the cycle after reset.
